// File: rtl/lane_gather_sum_pkg.sv
// Shared constants, state encoding and sizing helper for the lane gather/sum block.
package lane_gather_sum_pkg;

    localparam int DEF_N_LANES = 3;
    localparam int DEF_WIDTH   = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    // Internal sum width: enough headroom for n words of w bits, plus one spare bit.
    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/lane_gather_sum_capture.sv
// Per-lane capture slot: holds one word per set and raises got once it has it.
module lane_capture
    import lane_gather_sum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             collect,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_bits,
    output logic             in_ready,
    output logic             fire,
    output logic             got,
    output logic [WIDTH-1:0] hold
);

    logic             got_q;
    logic [WIDTH-1:0] hold_q;

    // Ready depends only on state and the got flag, never on valid.
    always_comb begin
        in_ready = collect & ~got_q & ~reset;
        fire     = in_valid & in_ready;
    end

    // Capture the lane word on handshake; clear releases the slot for the next set.
    always_ff @(posedge clock) begin
        if (reset) begin
            got_q  <= 1'b0;
            hold_q <= '0;
        end else if (clear) begin
            got_q  <= 1'b0;
        end else if (fire) begin
            got_q  <= 1'b1;
            hold_q <= in_bits;
        end
    end

    assign got  = got_q;
    assign hold = hold_q;

endmodule

// File: rtl/lane_gather_sum.sv
// Gathers one word from each producer lane and emits their sum with a carry flag.
module lane_gather_sum
    import lane_gather_sum_pkg::*;
#(
    parameter int N_LANES = DEF_N_LANES,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_LANES-1:0]         io_in_valid,
    output logic [N_LANES-1:0]         io_in_ready,
    input  logic [N_LANES*WIDTH-1:0]   io_in_bits,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [WIDTH-1:0]           io_out_bits,
    output logic                       io_out_carry
);

    localparam int SUM_W = sum_width(WIDTH, N_LANES);

    state_t                          state_q;
    state_t                          state_d;
    logic                            collect;
    logic                            out_fire;
    logic                            set_complete;
    logic [N_LANES-1:0]              fire;
    logic [N_LANES-1:0]              got;
    logic [N_LANES-1:0][WIDTH-1:0]   hold;
    logic [SUM_W-1:0]                sum_c;
    logic [WIDTH-1:0]                out_bits_q;
    logic                            out_carry_q;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_capture #(
            .WIDTH(WIDTH)
        ) u_capture (
            .clock    (clock),
            .reset    (reset),
            .collect  (collect),
            .clear    (out_fire),
            .in_valid (io_in_valid[g]),
            .in_bits  (io_in_bits[g*WIDTH +: WIDTH]),
            .in_ready (io_in_ready[g]),
            .fire     (fire[g]),
            .got      (got[g]),
            .hold     (hold[g])
        );
    end

    // Set completion and sum: lanes handshaking this cycle bypass their hold register.
    always_comb begin
        set_complete = collect;
        sum_c        = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            set_complete = set_complete & (got[i] | fire[i]);
            sum_c        = sum_c + SUM_W'(fire[i] ? io_in_bits[i*WIDTH +: WIDTH] : hold[i]);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: collect until the set is complete, then hold the result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (set_complete) state_d = EMIT;
            EMIT:    if (io_out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // State-decoded controls for the lanes and the output handshake.
    always_comb begin
        collect  = (state_q == COLLECT);
        out_fire = (state_q == EMIT) & io_out_ready;
    end

    // Result registers, loaded on the edge that completes a set.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_bits_q  <= '0;
            out_carry_q <= 1'b0;
        end else if (set_complete) begin
            out_bits_q  <= sum_c[WIDTH-1:0];
            out_carry_q <= |sum_c[SUM_W-1:WIDTH];
        end
    end

    assign io_out_valid = (state_q == EMIT);
    assign io_out_bits  = out_bits_q;
    assign io_out_carry = out_carry_q;

endmodule

// File: tb/tb_lane_gather_sum.sv
// Self-checking bench for lane_gather_sum: directed scenarios plus random traffic vs a queue model.
module tb_lane_gather_sum;

    localparam int N = 3;
    localparam int W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     io_in_valid;
    logic [N-1:0]     io_in_ready;
    logic [N*W-1:0]   io_in_bits;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [W-1:0]     io_out_bits;
    logic             io_out_carry;

    int total = 0;
    int bad   = 0;

    // Producer's pending word per lane (held until accepted) and words captured for the open set.
    logic [W-1:0] nxt [N];
    logic [W-1:0] cap [N][$];

    always #5 clock = ~clock;

    lane_gather_sum #(
        .N_LANES(N),
        .WIDTH  (W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_carry (io_out_carry)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_valid();
        logic v = 1'b1;
        for (int i = 0; i < N; i++) if (cap[i].size() == 0) v = 1'b0;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r = $urandom();
        if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return r;
    endfunction

    // One clock cycle: drive, check mid-cycle against the model, advance model, move to next negedge.
    task automatic step(input logic [N-1:0] v, input logic ordy);
        logic             ev;
        logic [N-1:0]     er;
        logic [63:0]      s;
        reset        = 1'b0;
        io_in_valid  = v;
        io_out_ready = ordy;
        for (int i = 0; i < N; i++) io_in_bits[i*W +: W] = v[i] ? nxt[i] : $urandom();
        #1;
        ev = model_valid();
        for (int i = 0; i < N; i++) er[i] = !ev && (cap[i].size() == 0);
        chk("in_ready", 64'(io_in_ready), 64'(er));
        chk("out_valid", 64'(io_out_valid), 64'(ev));
        if (ev) begin
            s = '0;
            for (int i = 0; i < N; i++) s = s + 64'(cap[i][0]);
            chk("out_bits", 64'(io_out_bits), 64'(s[W-1:0]));
            chk("out_carry", 64'(io_out_carry), 64'((s >> W) != 0));
            if (ordy) for (int i = 0; i < N; i++) void'(cap[i].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && er[i]) begin
                cap[i].push_back(nxt[i]);
                nxt[i] = rand_word();
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        io_in_valid  = '1;
        io_out_ready = 1'b0;
        io_in_bits   = '0;
        #1;
        chk("reset_in_ready", 64'(io_in_ready), 64'(0));
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        io_in_valid = '0;
        for (int i = 0; i < N; i++) cap[i].delete();
        #1;
        chk("rst_out_valid", 64'(io_out_valid), 64'(0));
        chk("rst_out_bits", 64'(io_out_bits), 64'(0));
        chk("rst_out_carry", 64'(io_out_carry), 64'(0));
        chk("rst_in_ready", 64'(io_in_ready), 64'(3'b111));
    endtask

    initial begin
        reset        = 1'b1;
        io_in_valid  = '0;
        io_in_bits   = '0;
        io_out_ready = 1'b0;
        @(negedge clock);
        do_reset();

        // All lanes in one cycle: 1+2+3.
        nxt[0] = 1; nxt[1] = 2; nxt[2] = 3;
        step(3'b111, 1'b0);
        chk("t1_bits", 64'(io_out_bits), 64'd6);
        chk("t1_carry", 64'(io_out_carry), 64'd0);
        step(3'b000, 1'b1);

        // Staggered arrivals: lane 2 at c0, lane 0 at c3, lane 1 at c5.
        nxt[0] = 32'h10; nxt[1] = 32'h20; nxt[2] = 32'h30;
        step(3'b100, 1'b0);
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        step(3'b010, 1'b0);
        chk("t2_valid", 64'(io_out_valid), 64'd1);
        chk("t2_bits", 64'(io_out_bits), 64'h60);
        step(3'b000, 1'b1);

        // Overflow sets carry.
        nxt[0] = 32'hFFFF_FFFF; nxt[1] = 32'hFFFF_FFFF; nxt[2] = 32'd2;
        step(3'b111, 1'b0);
        chk("t3_bits", 64'(io_out_bits), 64'd0);
        chk("t3_carry", 64'(io_out_carry), 64'd1);

        // Back-pressure for 4 cycles with lanes valid, then next set right after handshake.
        for (int k = 0; k < 4; k++) step(3'b111, 1'b0);
        step(3'b111, 1'b1);
        step(3'b111, 1'b0);
        step(3'b000, 1'b1);

        // Lane 0 re-asserts before the set completes; its word waits for the next set.
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        step(3'b111, 1'b0);
        step(3'b001, 1'b1);
        step(3'b001, 1'b0);
        step(3'b110, 1'b0);
        step(3'b000, 1'b1);

        // Reset mid-set discards partial captures.
        step(3'b011, 1'b0);
        do_reset();
        nxt[0] = 5; nxt[1] = 5; nxt[2] = 5;
        step(3'b111, 1'b0);
        chk("t6_bits", 64'(io_out_bits), 64'd15);
        step(3'b000, 1'b1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
